if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter ADDR_W, default 32, instruction address width.
REQ-002 Parameter DATA_W, default 32, instruction word width.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 Parameter NOP_WORD, default 32'h0000_0000, bubble word driven when no valid instruction.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 is_hold  in  1  downstream stall; same signal that freezes the IF/ID register.
REQ-008 branch_taken  in  1  redirect request from decode.
REQ-009 branch_target  in  ADDR_W  redirect address.
REQ-010 imem_req  out  1  instruction memory request.
REQ-011 imem_addr  out  ADDR_W  request address.
REQ-012 imem_ack  in  1  memory completion; data valid on imem_rdata in the same cycle.
REQ-013 imem_rdata  in  DATA_W  fetched word.
REQ-014 pc_plus4_IF  out  ADDR_W  address of presented instruction + 4.
REQ-015 inst_IF  out  DATA_W  presented instruction, or NOP_WORD.
REQ-016 fetch_stall  out  1  high when inst_IF is a bubble, not a fetched instruction.

Function
REQ-017 The block SHALL hold a PC register and a 3-state FSM: FETCH, HOLD, FLUSH.
REQ-018 PC arithmetic: pc+4 modulo 2^ADDR_W; 32'hFFFF_FFFC+4 SHALL wrap to 0.
REQ-019 branch_target[1:0] SHALL be ignored and loaded as 2'b00.
REQ-020 FETCH: imem_req=1, imem_addr=pc; imem_addr SHALL remain stable until imem_ack.
REQ-021 FETCH, no ack: inst_IF=NOP_WORD, fetch_stall=1, pc unchanged.
REQ-022 FETCH, ack, is_hold=0, branch_taken=0: inst_IF=imem_rdata and pc_plus4_IF=pc+4 in the same cycle (combinational path), fetch_stall=0; next pc=pc+4; stay FETCH.
REQ-023 FETCH, ack, is_hold=1: capture imem_rdata into inst_buf; go to HOLD; pc unchanged.
REQ-024 HOLD: imem_req=0, inst_IF=inst_buf, pc_plus4_IF=pc+4, fetch_stall=0; when is_hold=0, pc<=pc+4 and return to FETCH.
REQ-025 branch_taken=1 SHALL have priority over is_hold and ack handling; in that cycle inst_IF=NOP_WORD and fetch_stall=1.
REQ-026 Redirect in HOLD, or in FETCH with ack: pc<=branch_target, go to FETCH; the buffered or acked word SHALL be discarded.
REQ-027 Redirect in FETCH without ack: latch branch_target into pending_pc, go to FLUSH.
REQ-028 FLUSH: imem_req=1 at the old address, inst_IF=NOP_WORD, fetch_stall=1; on ack, discard data, pc<=pending_pc, go to FETCH.
REQ-029 A further branch_taken in FLUSH SHALL overwrite pending_pc (last redirect wins).
REQ-030 pc_plus4_IF during bubble cycles SHALL be pc+4 of the current pc (don't-care content, but deterministic).

Reset
REQ-031 While rst=1: pc<=RESET_PC, state<=FETCH, inst_buf<=0, pending_pc<=0; imem_req=0, inst_IF=NOP_WORD, fetch_stall=1, pc_plus4_IF=0.
REQ-032 Reset asserted mid-request or in FLUSH SHALL abandon the outstanding request; any ack arriving during rst SHALL be ignored.
REQ-033 First request SHALL issue in the first cycle after rst deasserts, at RESET_PC.

Verification
REQ-034 Zero-wait memory, no hold: after reset, imem_addr sequence 0,4,8,12 on consecutive cycles; pc_plus4_IF 4,8,12,16; fetch_stall=0.
REQ-035 Two-wait-state memory: 2 cycles of inst_IF=NOP_WORD, fetch_stall=1, imem_addr held at 0, then 3rd cycle presents word with pc_plus4_IF=4.
REQ-036 Ack of 32'h2408_0005 with is_hold=1 for 3 cycles: imem_req=0 for those cycles, inst_IF=32'h2408_0005 throughout, next fetch at 4 after release.
REQ-037 branch_taken with target 32'h0000_0103 while request at 8 unacked: FLUSH until ack, data discarded, next imem_addr=32'h0000_0100.
REQ-038 PC at 32'hFFFF_FFFC, ack: pc_plus4_IF=0; next imem_addr=0.
REQ-039 rst pulsed during a 3-cycle wait: imem_req=0 in rst cycle, late ack ignored, refetch at RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC register, imem handshake, hold buffer, redirect flush
// FSM: FETCH issues requests, HOLD replays a buffered word, FLUSH drains a redirected request.
module if_stage #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_0000,
  parameter logic [DATA_W-1:0]  NOP_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_hold,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] pc_plus4_IF,
  output logic [DATA_W-1:0] inst_IF,
  output logic              fetch_stall
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_FLUSH} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, pending_pc, pending_nxt;
  logic [ADDR_W-1:0] pc_inc, target;
  logic [DATA_W-1:0] inst_buf, inst_buf_nxt;

  assign pc_inc = pc + ADDR_W'(4);
  // Instruction addresses are word aligned; low target bits are dropped.
  assign target = {branch_target[ADDR_W-1:2], 2'b00};

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    pending_nxt  = pending_pc;
    inst_buf_nxt = inst_buf;
    imem_req     = 1'b0;
    imem_addr    = pc;
    inst_IF      = NOP_WORD;
    fetch_stall  = 1'b1;
    pc_plus4_IF  = pc_inc;
    if (rst) begin
      pc_plus4_IF = '0;
    end else begin
      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          if (branch_taken) begin
            if (imem_ack) begin
              pc_nxt = target;
            end else begin
              pending_nxt = target;
              state_nxt   = S_FLUSH;
            end
          end else if (imem_ack) begin
            inst_IF     = imem_rdata;
            fetch_stall = 1'b0;
            if (is_hold) begin
              inst_buf_nxt = imem_rdata;
              state_nxt    = S_HOLD;
            end else begin
              pc_nxt = pc_inc;
            end
          end
        end
        S_HOLD: begin
          if (branch_taken) begin
            pc_nxt    = target;
            state_nxt = S_FETCH;
          end else begin
            inst_IF     = inst_buf;
            fetch_stall = 1'b0;
            if (!is_hold) begin
              pc_nxt    = pc_inc;
              state_nxt = S_FETCH;
            end
          end
        end
        S_FLUSH: begin
          // Old request stays on the bus until memory completes it; its data is dropped.
          imem_req = 1'b1;
          if (imem_ack) begin
            pc_nxt    = branch_taken ? target : pending_pc;
            state_nxt = S_FETCH;
          end else if (branch_taken) begin
            pending_nxt = target;
          end
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      pending_pc <= '0;
      inst_buf   <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      pending_pc <= pending_nxt;
      inst_buf   <= inst_buf_nxt;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        is_hold = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc_plus4_IF;
  logic [31:0] inst_IF;
  logic        fetch_stall;

  int total = 0;
  int bad = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst(rst), .is_hold(is_hold), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_plus4_IF(pc_plus4_IF),
    .inst_IF(inst_IF), .fetch_stall(fetch_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, apply inputs just after the edge, then settle to the falling edge.
  task automatic cyc(input logic r, input logic a, input logic [31:0] d,
                     input logic h, input logic b, input logic [31:0] t);
    @(posedge clk);
    #1;
    rst = r; imem_ack = a; imem_rdata = d; is_hold = h;
    branch_taken = b; branch_target = t;
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                            input logic [31:0] pc4, input logic [31:0] inst, input logic stall);
    chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
    if (req) chk({tag, ".addr"}, imem_addr, addr);
    chk({tag, ".pc4"}, pc_plus4_IF, pc4);
    chk({tag, ".inst"}, inst_IF, inst);
    chk({tag, ".stall"}, {31'd0, fetch_stall}, {31'd0, stall});
  endtask

  initial begin
    // reset with a stray ack present
    cyc(1, 1, 32'hDEAD_BEEF, 0, 0, 0);
    expect_out("rst0", 0, 0, 0, NOP, 1);
    cyc(1, 0, 0, 0, 0, 0);
    expect_out("rst1", 0, 0, 0, NOP, 1);

    // zero-wait streaming
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 32'h1000_0000 + i, 0, 0, 0);
      expect_out("stream", 1, 32'(4 * i), 32'(4 * i + 4), 32'h1000_0000 + i, 0);
    end

    // two wait states
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    expect_out("wait0", 1, 0, 4, NOP, 1);
    cyc(0, 0, 0, 0, 0, 0);
    expect_out("wait1", 1, 0, 4, NOP, 1);
    cyc(0, 1, 32'hAAAA_5555, 0, 0, 0);
    expect_out("wait2", 1, 0, 4, 32'hAAAA_5555, 0);

    // hold: ack under hold, two more held cycles, release
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h2408_0005, 1, 0, 0);
    expect_out("hold_ack", 1, 0, 4, 32'h2408_0005, 0);
    cyc(0, 1, 32'h1111_1111, 1, 0, 0);
    expect_out("hold1", 0, 0, 4, 32'h2408_0005, 0);
    cyc(0, 0, 0, 1, 0, 0);
    expect_out("hold2", 0, 0, 4, 32'h2408_0005, 0);
    cyc(0, 0, 0, 0, 0, 0);
    expect_out("hold_rel", 0, 0, 4, 32'h2408_0005, 0);
    cyc(0, 1, 32'h0000_0044, 0, 0, 0);
    expect_out("after_hold", 1, 4, 8, 32'h0000_0044, 0);

    // redirect while request at 8 is outstanding
    cyc(0, 0, 0, 0, 1, 32'h0000_0103);
    expect_out("br_noack", 1, 8, 12, NOP, 1);
    cyc(0, 0, 0, 0, 0, 0);
    expect_out("flush", 1, 8, 12, NOP, 1);
    cyc(0, 1, 32'hBAD0_BAD0, 0, 0, 0);
    expect_out("flush_ack", 1, 8, 12, NOP, 1);
    cyc(0, 0, 0, 0, 0, 0);
    expect_out("redir", 1, 32'h100, 32'h104, NOP, 1);

    // last redirect in flush wins
    cyc(0, 0, 0, 0, 1, 32'h0000_0010);
    cyc(0, 0, 0, 0, 1, 32'h0000_0020);
    expect_out("flush_br", 1, 32'h100, 32'h104, NOP, 1);
    cyc(0, 1, 32'hBAD1_BAD1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    expect_out("last_wins", 1, 32'h20, 32'h24, NOP, 1);

    // redirect with ack discards the word; misaligned target is aligned
    cyc(0, 1, 32'h5555_0000, 0, 1, 32'hFFFF_FFFF);
    expect_out("br_ack", 1, 32'h20, 32'h24, NOP, 1);
    cyc(0, 1, 32'h7777_0000, 0, 0, 0);
    expect_out("wrap", 1, 32'hFFFF_FFFC, 32'h0, 32'h7777_0000, 0);
    cyc(0, 1, 32'h7777_0001, 0, 0, 0);
    expect_out("wrapped", 1, 32'h0, 32'h4, 32'h7777_0001, 0);

    // redirect from HOLD drops the buffered word
    cyc(0, 1, 32'h3333_0000, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'h0000_0200);
    expect_out("hold_br", 0, 0, 32'h8, NOP, 1);
    cyc(0, 0, 0, 0, 0, 0);
    expect_out("hold_redir", 1, 32'h200, 32'h204, NOP, 1);

    // reset during a wait, late ack during reset ignored
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'hDEAD_0001, 0, 0, 0);
    expect_out("rst_mid", 0, 0, 0, NOP, 1);
    cyc(0, 0, 0, 0, 0, 0);
    expect_out("refetch", 1, 0, 4, NOP, 1);
    cyc(0, 1, 32'h0BAD_F00D, 0, 0, 0);
    expect_out("refetch_ack", 1, 0, 4, 32'h0BAD_F00D, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
